// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC decimator.
// Sets the input sample width, the stage-count limits and the accumulator width rule.
package cic_pkg;
    localparam int DIN_W      = 16;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 6;

    // Enough headroom for a gain of up to 2^(stages*clog2(rate)).
    function automatic int acc_width(input int rate, input int stages);
        return DIN_W + stages * $clog2(rate);
    endfunction
endpackage

// File: rtl/cic_comb.sv
// One CIC comb stage with a differential delay of 1 (at the decimated rate).
// The delay register loads only while en is high.
module cic_comb #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    logic [W-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst)     prev <= '0;
        else if (en) prev <= x;
    end

    assign y = x - prev;
endmodule

// File: rtl/cic_deci.sv
// CIC decimator: STAGES integrators at the input rate, STAGES combs at 1/RATE.
// The combs are combinational from the new integrator value, so dout lands one clk after the decimating cke.
module cic_deci
    import cic_pkg::*;
#(
    parameter int RATE   = 4,
    parameter int STAGES = 3,
    parameter int W_ACC  = acc_width(RATE, STAGES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cke,
    input  logic signed [15:0] din,
    output logic signed [15:0] dout,
    output logic               cke_out
);
    localparam int DIV_W = $clog2(RATE);

    logic [STAGES-1:0][W_ACC-1:0] integ, integ_nxt;
    logic [STAGES:0][W_ACC-1:0]   comb_x;
    logic [W_ACC-1:0]             din_ext;
    logic [DIV_W-1:0]             div;
    logic                         decim;
    logic [W_ACC-17:0]            unused_lsbs;

    assign din_ext = {{(W_ACC-DIN_W){din[15]}}, din};
    assign decim   = cke && (div == '0);

    // Unpipelined cascade; modular wrap is relied on and cancelled by the combs.
    always_comb begin
        integ_nxt    = integ;
        integ_nxt[0] = integ[0] + din_ext;
        for (int k = 1; k < STAGES; k++)
            integ_nxt[k] = integ[k] + integ_nxt[k-1];
    end

    assign comb_x[0] = integ_nxt[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_comb
        cic_comb #(.W(W_ACC)) u_comb (
            .clk (clk),
            .rst (rst),
            .en  (decim),
            .x   (comb_x[k]),
            .y   (comb_x[k+1])
        );
    end

    // Keeping the top 16 bits is the arithmetic shift right by W_ACC-16.
    assign unused_lsbs = comb_x[STAGES][W_ACC-17:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            integ   <= '0;
            div     <= '0;
            dout    <= '0;
            cke_out <= 1'b0;
        end else begin
            cke_out <= decim;
            if (cke) begin
                integ <= integ_nxt;
                div   <= (div == '0) ? DIV_W'(RATE - 1) : div - DIV_W'(1);
            end
            if (decim)
                dout <= comb_x[STAGES][W_ACC-1 -: 16];
        end
    end
endmodule

// File: tb/tb_cic_deci.sv
// Directed bench for cic_deci: one RATE=2/STAGES=1 instance and one default (RATE=4/STAGES=3) instance.
// Expected outputs are hand-derived from the CIC step/impulse responses.
module tb_cic_deci;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cke = 1'b0;
    logic signed [15:0] din = '0;
    logic signed [15:0] dout_a, dout_b;
    logic               cko_a, cko_b;
    int                 checks   = 0;
    int                 failures = 0;

    always #5 clk = ~clk;

    cic_deci #(.RATE(2), .STAGES(1)) dut_a (
        .clk(clk), .rst(rst), .cke(cke), .din(din), .dout(dout_a), .cke_out(cko_a)
    );
    cic_deci dut_b (
        .clk(clk), .rst(rst), .cke(cke), .din(din), .dout(dout_b), .cke_out(cko_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then settle at the falling edge for sampling.
    task automatic step(input logic c, input logic signed [15:0] d);
        cke = c;
        din = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 16'sd0);
        step(1'b0, 16'sd0);
        rst = 1'b0;
    endtask

    int exp_ramp1000 [4] = '{15, 500, 984, 1000};
    int exp_ramp500  [4] = '{7, 250, 492, 500};
    int nout;
    int last;

    initial begin
        @(negedge clk);
        do_reset();
        chk("reset_dout_a", dout_a, 0);
        chk("reset_cko_a", cko_a, 0);
        chk("reset_dout_b", dout_b, 0);
        chk("reset_cko_b", cko_b, 0);

        // Impulse through RATE=2, STAGES=1
        step(1'b1, 16'sd16384);
        chk("imp_cko0", cko_a, 1);
        chk("imp_dout0", dout_a, 8192);
        step(1'b1, 16'sd0);
        chk("imp_cko1", cko_a, 0);
        chk("imp_hold1", dout_a, 8192);
        step(1'b1, 16'sd0);
        chk("imp_cko2", cko_a, 1);
        chk("imp_dout2", dout_a, 0);
        step(1'b1, 16'sd0);
        step(1'b1, 16'sd0);
        chk("imp_cko4", cko_a, 1);
        chk("imp_dout4", dout_a, 0);

        // DC 1000, back-to-back cke
        do_reset();
        nout = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 16'sd1000);
            chk("dc_cko", cko_b, (i % 4 == 0) ? 1 : 0);
            if (i % 4 == 0) begin
                chk("dc_dout", dout_b, (nout < 4) ? exp_ramp1000[nout] : 1000);
                nout++;
            end
        end

        // cke 1-in-5 clk; din garbage between strobes must be ignored
        do_reset();
        nout = 0;
        last = 0;
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 5; j++) begin
                if (j == 0) step(1'b1, 16'sd1000);
                else        step(1'b0, 16'sd7777);
                chk("pulse_cko", cko_b, (j == 0 && i % 4 == 0) ? 1 : 0);
                if (j == 0 && i % 4 == 0) begin
                    last = (nout < 4) ? exp_ramp1000[nout] : 1000;
                    nout++;
                end
                chk("pulse_dout", dout_b, last);
            end
        end

        // Full-scale negative DC; integrators wrap
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            step(1'b1, -16'sd32768);
            if (i % 4 == 0 && i >= 12) chk("neg_dout", dout_b, -32768);
        end

        // Reset mid-frame with cke high, then DC 500
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 16'sd500);
        rst = 1'b1;
        step(1'b1, 16'sd1234);
        chk("mid_rst_dout", dout_b, 0);
        chk("mid_rst_cko", cko_b, 0);
        step(1'b1, 16'sd1234);
        chk("mid_rst_dout2", dout_b, 0);
        chk("mid_rst_cko2", cko_b, 0);
        rst = 1'b0;
        nout = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 16'sd500);
            chk("post_rst_cko", cko_b, (i % 4 == 0) ? 1 : 0);
            if (i % 4 == 0) begin
                chk("post_rst_dout", dout_b, (nout < 4) ? exp_ramp500[nout] : 500);
                nout++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
